downsizing_rr_arbiter: RTL and testbench
========================================

// Module: downsizing_rr_arbiter
// PURPOSE
//  Shares one 2W->W downsizing datapath among N AXI-Stream requesters.
//  Round-robin grant per 2W word; a granted word is sent as two W beats, high half
//  first, and is never interleaved with another requester's word.
//  Sits between N producers of 2W-wide words and one W-wide consumer.
//  Provides out_tid and out_tlast so the consumer can demultiplex.
// PARAMETERS
//  W  32  width of one output beat; input words are 2*W
//  N  4   number of requesters, N >= 2
// PORTS
//  aclk        in   1          clock, all logic on rising edge
//  aresetn     in   1          synchronous active-low reset
//  in_tdata    in   N*2*W      requester i word at [i*2W +: 2W]
//  in_tvalid   in   N          per-requester valid
//  in_tready   out  N          per-requester ready, combinational, one-hot or zero
//  out_tdata   out  W          registered output beat
//  out_tvalid  out  1          registered, decoded from state
//  out_tlast   out  1          1 on low-half beat (second beat of pair)
//  out_tid     out  $clog2(N)  registered index of requester owning current beat
//  out_tready  in   1          consumer ready
// BEHAVIOUR
//  Reset (aresetn=0 at posedge): state=ST_IDLE, out_tvalid=0, out_tlast=0,
//   out_tid=0, last-grant pointer=N-1. in_tready=0 while reset is asserted.
//   out_tdata and the hold register are not reset.
//  FSM, 3 states: ST_IDLE (out_tvalid=0), ST_HIGH (high half on out), ST_LOW (low half on out).
//  Grant pick: first i with in_tvalid[i]=1, searching ptr+1, ptr+2 .. wrapping mod N.
//  "Take" = in_tready[g]=1 for the picked g in the same cycle. Fires:
//   ST_IDLE and any in_tvalid; or ST_LOW and out_tready and any in_tvalid.
//  On take: hold <= in_tdata[g]; out_tdata <= word[2W-1:W]; out_tid <= g;
//   ptr <= g; next state ST_HIGH.
//  ST_HIGH & out_tready: out_tdata <= hold[W-1:0]; next ST_LOW; in_tready=0.
//  ST_LOW & out_tready & no valid: next ST_IDLE.
//  out_tready=0 in ST_HIGH/ST_LOW: state and all outputs hold; no take.
//  Latency: input accepted at cycle t -> high beat valid at t+1.
//   Sustained rate: 1 output beat/cycle, no bubble between pairs.
//  Fairness: all N valid continuously -> grants 0,1,..,N-1,0,..
//   A requester waits at most N-1 other words.
//  in_tvalid not asserted -> never granted. ptr moves only on take.
//  out_tlast = (state==ST_LOW); out_tvalid = (state != ST_IDLE).
//  Reset mid-pair: pair abandoned, low half never emitted; the word was already
//   handshaken, so it is lost. Upstream must reset together with this block.
// STRUCTURE
//  downsizing_pkg: state_t enum {ST_IDLE, ST_HIGH, ST_LOW};
//   function for the index width, $clog2(N) floored at 1.
//  Sub-module rr_arbiter #(N): combinational; inputs req[N] and ptr;
//   outputs grant index and any_req. Instantiated once.
//  Top level: FSM, hold register, output registers, in_tready decode.
// TESTING (W=8, N=4)
//  1 Reset: aresetn=0 for 2 cycles with in_tvalid=4'hF -> in_tready=0, out_tvalid=0;
//    after release, first grant is requester 0.
//  2 Single word: req1 sends 16'hA55A, out_tready=1 -> beats 8'hA5 (tid=1, tlast=0),
//    then 8'h5A (tid=1, tlast=1), then out_tvalid=0.
//  3 All four valid continuously, out_tready=1 -> tid sequence 0,0,1,1,2,2,3,3,0,0;
//    out_tvalid stays 1 with no gaps.
//  4 Backpressure: out_tready=0 for 3 cycles during ST_HIGH -> out_tdata, tid and tlast
//    stable, in_tready=4'h0; resumes with the low half.
//  5 Starvation check: req2 valid always, req0 pulses valid -> strictly alternating
//    grants 2,0,2,0 while both are pending.
//  6 Reset asserted in ST_HIGH -> next cycle out_tvalid=0; low half never appears;
//    after release, grant order restarts at requester 0.

Source files
------------

// File: rtl/downsizing_pkg.sv
// Shared types and helpers for the downsizing round-robin arbiter.
package downsizing_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   // Index width for n requesters, kept at least one bit so N=1 corner cases still elaborate.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo N.
module rr_arbiter
   import downsizing_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          any_req
);

   always_comb begin
      // NOTE: every output gets a default before the search loop, so no path leaves it unassigned (no latch).
      grant   = '0;
      any_req = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N;
         if (!any_req && req[idx]) begin
            grant   = IW'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/downsizing_rr_arbiter.sv
// Round-robin shares one 2W->W downsizer among N AXI-Stream requesters; each word leaves as high then low beat.
module downsizing_rr_arbiter
   import downsizing_pkg::*;
#(
   parameter int W = 32,
   parameter int N = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [N*2*W-1:0]              in_tdata,
   input  logic [N-1:0]                  in_tvalid,
   output logic [N-1:0]                  in_tready,
   output logic [W-1:0]                  out_tdata,
   output logic                          out_tvalid,
   output logic                          out_tlast,
   output logic [idx_width(N)-1:0]       out_tid,
   input  logic                          out_tready
);

   localparam int IW = idx_width(N);

   state_t         state, state_nxt;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  gnt;
   logic           any_req;
   logic           take;
   logic [2*W-1:0] word;
   logic [W-1:0]   hold;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_rr_arbiter (
      .req     (in_tvalid),
      .ptr     (ptr),
      .grant   (gnt),
      .any_req (any_req)
   );

   assign word = in_tdata[gnt*2*W +: 2*W];

   // A new word is accepted only when the output slot frees up this cycle; reset blocks it outright.
   assign take = aresetn && any_req &&
                 ((state == ST_IDLE) || ((state == ST_LOW) && out_tready));

   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_tready[i] = take && (gnt == IW'(i));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (take) state_nxt = ST_HIGH;
         ST_HIGH: if (out_tready) state_nxt = ST_LOW;
         ST_LOW:  if (out_tready) state_nxt = take ? ST_HIGH : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= ST_IDLE;
         out_tid <= '0;
         ptr     <= IW'(N - 1);
      end else begin
         state <= state_nxt;
         if (take) begin
            ptr     <= gnt;
            out_tid <= gnt;
         end
      end
   end

   // NOTE: datapath registers carry no reset; out_tvalid qualifies them, so reset values would be wasted logic.
   always_ff @(posedge aclk) begin
      if (take) begin
         hold      <= word[W-1:0];
         out_tdata <= word[2*W-1:W];
      end else if ((state == ST_HIGH) && out_tready) begin
         out_tdata <= hold;
      end
   end

   assign out_tvalid = (state != ST_IDLE);
   assign out_tlast  = (state == ST_LOW);

endmodule

// File: tb/tb_downsizing_rr_arbiter.sv
// Directed self-checking bench for downsizing_rr_arbiter at W=8, N=4.
module tb_downsizing_rr_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           aclk;
   logic           aresetn;
   logic [N*2*W-1:0] in_tdata;
   logic [N-1:0]   in_tvalid;
   logic [N-1:0]   in_tready;
   logic [W-1:0]   out_tdata;
   logic           out_tvalid;
   logic           out_tlast;
   logic [1:0]     out_tid;
   logic           out_tready;

   int n_tests = 0;
   int n_fail  = 0;

   downsizing_rr_arbiter #(
      .W (W),
      .N (N)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tlast  (out_tlast),
      .out_tid    (out_tid),
      .out_tready (out_tready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_beat(input string tag, input logic [7:0] data,
                             input logic [1:0] tid, input logic last);
      check({tag, ".tvalid"}, 32'(out_tvalid), 32'd1);
      check({tag, ".tdata"},  32'(out_tdata),  32'(data));
      check({tag, ".tid"},    32'(out_tid),    32'(tid));
      check({tag, ".tlast"},  32'(out_tlast),  32'(last));
   endtask

   task automatic do_reset();
      aresetn   = 1'b0;
      in_tvalid = 4'h0;
      step();
      aresetn = 1'b1;
   endtask

   initial begin
      // Requester i word = {A0+i, B0+i}; requester 1 later overridden with A55A.
      for (int i = 0; i < N; i++) begin
         in_tdata[i*16 +: 16] = {8'(8'hA0 + i), 8'(8'hB0 + i)};
      end
      aresetn    = 1'b0;
      in_tvalid  = 4'hF;
      out_tready = 1'b1;

      // 1: reset with all requesters valid
      step();
      check("rst.in_tready0", 32'(in_tready), 32'h0);
      step();
      check("rst.in_tready1", 32'(in_tready), 32'h0);
      check("rst.tvalid",     32'(out_tvalid), 32'd0);
      check("rst.tlast",      32'(out_tlast),  32'd0);
      check("rst.tid",        32'(out_tid),    32'd0);
      aresetn = 1'b1;
      #1;
      check("rst.first_grant", 32'(in_tready), 32'h1);
      in_tvalid = 4'h0;
      #1;
      check("rst.no_valid_no_ready", 32'(in_tready), 32'h0);

      // 2: single word from requester 1 (ptr still 3)
      in_tdata[16 +: 16] = 16'hA55A;
      in_tvalid = 4'b0010;
      #1;
      check("single.in_tready", 32'(in_tready), 32'h2);
      step();
      in_tvalid = 4'h0;
      check_beat("single.hi", 8'hA5, 2'd1, 1'b0);
      check("single.hi_in_tready", 32'(in_tready), 32'h0);
      step();
      check_beat("single.lo", 8'h5A, 2'd1, 1'b1);
      step();
      check("single.idle", 32'(out_tvalid), 32'd0);
      in_tdata[16 +: 16] = 16'hA1B1;

      // 3: all valid continuously after reset -> 0,0,1,1,2,2,3,3,0,0
      do_reset();
      in_tvalid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         logic [1:0] tid;
         tid = 2'((k / 2) % 4);
         step();
         check_beat($sformatf("rr.beat%0d", k),
                    (k % 2 == 0) ? 8'(8'hA0 + tid) : 8'(8'hB0 + tid), tid, (k % 2 == 1));
      end

      // 4: backpressure while requester 1's high half is on the bus
      step();
      check_beat("bp.hi", 8'hA1, 2'd1, 1'b0);
      out_tready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp.in_tready%0d", k), 32'(in_tready), 32'h0);
         step();
         check_beat($sformatf("bp.hold%0d", k), 8'hA1, 2'd1, 1'b0);
      end
      out_tready = 1'b1;
      step();
      check_beat("bp.lo", 8'hB1, 2'd1, 1'b1);
      in_tvalid = 4'h0;
      step();
      check("bp.idle", 32'(out_tvalid), 32'd0);

      // 5: req2 always valid, req0 valid for a while (ptr=1) -> 2,2,0,0,2,2,0,0
      in_tvalid = 4'b0101;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] tid;
         tid = ((k / 2) % 2 == 0) ? 2'd2 : 2'd0;
         step();
         check_beat($sformatf("fair.beat%0d", k),
                    (k % 2 == 0) ? 8'(8'hA0 + tid) : 8'(8'hB0 + tid), tid, (k % 2 == 1));
      end
      in_tvalid = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         step();
         check_beat($sformatf("solo.beat%0d", k), (k % 2 == 0) ? 8'hA2 : 8'hB2, 2'd2, (k % 2 == 1));
      end
      in_tvalid = 4'h0;
      step();
      check("solo.idle", 32'(out_tvalid), 32'd0);

      // 6: reset in ST_HIGH abandons the pair; order restarts at requester 0
      in_tvalid = 4'b0010;
      step();
      check_beat("mid.hi", 8'hA1, 2'd1, 1'b0);
      aresetn   = 1'b0;
      in_tvalid = 4'hF;
      #1;
      check("mid.rst_in_tready", 32'(in_tready), 32'h0);
      step();
      check("mid.rst_tvalid", 32'(out_tvalid), 32'd0);
      check("mid.rst_tlast",  32'(out_tlast),  32'd0);
      check("mid.rst_tid",    32'(out_tid),    32'd0);
      aresetn = 1'b1;
      #1;
      check("mid.restart_ready", 32'(in_tready), 32'h1);
      step();
      check_beat("mid.restart_hi", 8'hA0, 2'd0, 1'b0);
      in_tvalid = 4'h0;
      step();
      check_beat("mid.restart_lo", 8'hB0, 2'd0, 1'b1);
      step();
      check("mid.idle", 32'(out_tvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
